// File: rtl/operand_entry_ctrl_pkg.sv
// Shared types and defaults for the operand entry front-end: FSM state
// encoding, operand width and debounce timing.
package operand_entry_ctrl_pkg;

    localparam int unsigned DATA_W_DEF          = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 240000;

    typedef enum logic [0:0] {
        EDIT = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Counter width for a given debounce length; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_w(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, stability counter and a
// registered one-cycle pulse on each accepted press (debounced 1->0).
module key_debounce
    import operand_entry_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = cnt_w(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             lvl_q, lvl_d;
    logic             lvl_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // A level is accepted only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d   = '0;
        lvl_d   = lvl_q;
        press_d = lvl_dly_q & ~lvl_q;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            lvl_q     <= 1'b1;
            lvl_dly_q <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw_n_i};
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Operand entry front-end: debounced load/calculate keys drive operand
// registers and the EDIT/SHOW display mode for the downstream adder stage.
module operand_entry_ctrl
    import operand_entry_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              key_a_n,
    input  logic              key_b_n,
    input  logic              key_cal_n,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    output logic              show_result,
    output logic              calc_pulse
);

    logic press_a, press_b, press_cal;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .raw_n_i(key_a_n), .press_o(press_a)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .rst_n(rst_n), .raw_n_i(key_b_n), .press_o(press_b)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cal (
        .clk(clk), .rst_n(rst_n), .raw_n_i(key_cal_n), .press_o(press_cal)
    );

    state_e            state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              a_vld_q, a_vld_d;
    logic              b_vld_q, b_vld_d;
    logic              op_valid_q, op_valid_d;
    logic              calc_q, calc_d;
    logic              load;

    // Loads always win over a same-cycle calculate press.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        a_vld_d = a_vld_q;
        b_vld_d = b_vld_q;
        calc_d  = 1'b0;
        load    = press_a | press_b;
        if (press_a) begin
            op_a_d  = sw;
            a_vld_d = 1'b1;
        end
        if (press_b) begin
            op_b_d  = sw;
            b_vld_d = 1'b1;
        end
        case (state_q)
            EDIT: begin
                if (press_cal && a_vld_q && b_vld_q && !load) begin
                    state_d = SHOW;
                    calc_d  = 1'b1;
                end
            end
            SHOW: begin
                if (load) begin
                    state_d = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
        op_valid_d = a_vld_d & b_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EDIT;
            op_a_q     <= '0;
            op_b_q     <= '0;
            a_vld_q    <= 1'b0;
            b_vld_q    <= 1'b0;
            op_valid_q <= 1'b0;
            calc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            a_vld_q    <= a_vld_d;
            b_vld_q    <= b_vld_d;
            op_valid_q <= op_valid_d;
            calc_q     <= calc_d;
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_valid    = op_valid_q;
    assign show_result = (state_q == SHOW);
    assign calc_pulse  = calc_q;

endmodule
